y86_instr_writer: RTL and testbench

Byte-serial Y86-64 instruction encoder and instruction-memory writer. It accepts one decoded instruction per handshake as icode, ifun, rA, rB and valC. It emits the instruction's byte encoding, one byte per cycle, into the 1024-byte instruction memory that the fetch stage reads. It is the write side of the fetch path, used by the program loader and the testbenches to build programs from fields instead of hand-written byte images.

---
 rtl/y86_pkg.sv | 53 +++++
 rtl/y86_instr_writer.sv | 170 +++++++++++++++++
 tb/tb_y86_instr_writer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: icode constants and encoding helpers.
// Used by the instruction writer, fetch and decode stages.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Encoded length in bytes; 0 marks an illegal icode.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            I_HALT, I_NOP, I_RET:                len = 4'd1;
            I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:    len = 4'd2;
            I_JXX, I_CALL:                       len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 4'd10;
            default:                             len = 4'd0;
        endcase
        return len;
    endfunction

    // True when byte1 carries {rA, rB}.
    function automatic logic has_regs(input logic [3:0] icode);
        logic r;
        case (icode)
            I_CMOVXX, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Byte index of the least-significant valC byte.
    function automatic logic [3:0] valc_offset(input logic [3:0] icode);
        logic [3:0] off;
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: off = 4'd2;
            I_JXX, I_CALL:                off = 4'd1;
            default:                      off = 4'd0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/y86_instr_writer.sv
// Byte-serial Y86-64 encoder writing one byte per cycle into instruction memory.
// Ports: clk/rst, addr_load/addr_in (write pointer load), in_valid/in_ready +
// icode/ifun/rA/rB/valC (instruction handshake), wr_en/wr_addr/wr_data (memory
// write port), pc_out (write pointer), err (reject pulse), busy (emitting).
module y86_instr_writer
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          addr_load,
    input  logic [AW-1:0] addr_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    icode,
    input  logic [3:0]    ifun,
    input  logic [3:0]    rA,
    input  logic [3:0]    rB,
    input  logic [63:0]   valC,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] pc_out,
    output logic          err,
    output logic          busy
);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    icode_q, icode_d;
    logic [3:0]    ifun_q, ifun_d;
    logic [3:0]    ra_q, ra_d;
    logic [3:0]    rb_q, rb_d;
    logic [63:0]   valc_q, valc_d;
    // One extra bit so a pointer sitting at MEM_BYTES still fails the fit check.
    logic [AW:0]   pc_q, pc_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          err_q, err_d;

    logic          accept;
    logic          last;
    logic [AW:0]   start;
    logic [3:0]    new_len;
    logic [AW+1:0] end_addr;
    logic          legal;
    logic [3:0]    off;
    logic [2:0]    k;

    assign last     = (state_q == S_EMIT) && (idx_q == len_q - 4'd1);
    assign in_ready = (state_q == S_IDLE) || last;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_EMIT);

    // A new instruction begins where the previous one ends, or at addr_in
    // when loading from IDLE in the same cycle.
    always_comb begin
        start = pc_q;
        if (state_q == S_EMIT)
            start = pc_q + (AW+1)'(1);
        else if (addr_load)
            start = {1'b0, addr_in};
    end

    assign new_len  = instr_len(icode);
    assign end_addr = {1'b0, start} + (AW+2)'(new_len);
    assign legal    = (new_len != 4'd0) && (end_addr <= (AW+2)'(MEM_BYTES));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        pc_d    = pc_q;
        err_d   = 1'b0;

        if (state_q == S_IDLE) begin
            if (addr_load)
                pc_d = {1'b0, addr_in};
        end else begin
            pc_d  = pc_q + (AW+1)'(1);
            idx_d = idx_q + 4'd1;
            if (last)
                state_d = S_IDLE;
        end

        if (accept) begin
            if (legal) begin
                state_d = S_EMIT;
                idx_d   = 4'd0;
                len_d   = new_len;
                icode_d = icode;
                ifun_d  = ifun;
                ra_d    = rA;
                rb_d    = rB;
                valc_d  = valC;
                pc_d    = start;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Outputs are computed from next state so the write flop lines up with
    // the cycle in which that byte index is current.
    assign off = valc_offset(icode_d);
    assign k   = idx_d[2:0] - off[2:0];

    always_comb begin
        wr_en_d   = (state_d == S_EMIT);
        wr_addr_d = pc_d[AW-1:0];
        unique case (1'b1)
            (idx_d == 4'd0):
                wr_data_d = {icode_d, ifun_d};
            (idx_d == 4'd1) && has_regs(icode_d):
                wr_data_d = {ra_d, rb_d};
            default:
                wr_data_d = valc_d[{k, 3'b000} +: 8];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            icode_q   <= '0;
            ifun_q    <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            valc_q    <= '0;
            pc_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            icode_q   <= icode_d;
            ifun_q    <= ifun_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            valc_q    <= valc_d;
            pc_q      <= pc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
    assign pc_out  = pc_q[AW-1:0];

endmodule

// File: tb/tb_y86_instr_writer.sv
// Scoreboard bench for y86_instr_writer: a byte-level model pushes expected
// writes/rejects, a negedge monitor pops and compares every DUT output event.
module tb_y86_instr_writer;

    localparam int AW  = 10;
    localparam int MEM = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          addr_load;
    logic [AW-1:0] addr_in;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    icode, ifun, ra, rb;
    logic [63:0]   valc;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] pc_out;
    logic          err;
    logic          busy;

    y86_instr_writer #(.MEM_BYTES(MEM), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .addr_load(addr_load), .addr_in(addr_in),
        .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .rA(ra), .rB(rb), .valC(valc),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_out(pc_out), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int addr;
        int data;
    } ev_t;

    ev_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  pc_m = 0;
    int  strobes = 0;
    int  wcyc[int];
    bit  rdy_chk = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe or error pulse must match the head of the queue.
    always @(negedge clk) begin
        ev_t e;
        if (wr_en === 1'b1 || err === 1'b1) begin
            if (wr_en === 1'b1) begin
                strobes++;
                wcyc[int'(wr_addr)] = cyc;
            end
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_output: wr_en=%0b err=%0b addr=%0h expected none",
                         wr_en, err, wr_addr);
            end else begin
                e = sb.pop_front();
                if (e.is_err) begin
                    check("err_pulse", err, 1);
                    check("err_no_write", wr_en, 0);
                end else begin
                    check("wr_en", wr_en, 1);
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("no_err_on_write", err, 0);
                end
                if (rdy_chk && wr_en && (wr_addr == 25 || wr_addr == 34))
                    check("in_ready_b2b", in_ready, 1);
            end
        end
    end

    // Reference model: length and layout straight from the encoding rules.
    task automatic model_push(input int ic, input int f, input int a, input int b,
                              input logic [63:0] c, input int start);
        int len;
        int off;
        bit regs;
        ev_t e;
        case (ic)
            0, 1, 9:          len = 1;
            2, 6, 10, 11:     len = 2;
            7, 8:             len = 9;
            3, 4, 5:          len = 10;
            default:          len = 0;
        endcase
        regs = (ic >= 2 && ic <= 6) || ic == 10 || ic == 11;
        off  = (ic >= 3 && ic <= 5) ? 2 : 1;
        if (len == 0 || start + len > MEM) begin
            e.is_err = 1; e.addr = 0; e.data = 0;
            sb.push_back(e);
            return;
        end
        e.is_err = 0;
        e.addr = start; e.data = ic * 16 + f;
        sb.push_back(e);
        if (regs) begin
            e.addr = start + 1; e.data = a * 16 + b;
            sb.push_back(e);
        end
        if (len >= 9) begin
            for (int i = 0; i < 8; i++) begin
                e.addr = start + off + i;
                e.data = int'((c >> (8 * i)) & 64'hFF);
                sb.push_back(e);
            end
        end
        pc_m = start + len;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    endtask

    task automatic do_load(input int a);
        wait_idle();
        addr_load = 1; addr_in = AW'(a);
        @(posedge clk); #1;
        addr_load = 0;
        pc_m = a;
    endtask

    task automatic send(input int ic, input int f, input int a, input int b,
                        input logic [63:0] c, input bit ld, input int ld_addr);
        bit ok = 0;
        if (ld) wait_idle();
        icode = 4'(ic); ifun = 4'(f); ra = 4'(a); rb = 4'(b); valc = c;
        addr_load = ld; addr_in = AW'(ld_addr);
        in_valid = 1;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
            in_valid = 0; addr_load = 0;
            return;
        end
        model_push(ic, f, a, b, c, ld ? ld_addr : pc_m);
        @(posedge clk); #1;
        in_valid = 0; addr_load = 0;
    endtask

    task automatic drain();
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int s0;
        rst = 1; addr_load = 0; addr_in = '0; in_valid = 0;
        icode = '0; ifun = '0; ra = '0; rb = '0; valc = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_pc_out", pc_out, 0);
        rst = 0;
        pc_m = 0;

        send(1, 0, 0, 0, 64'h0, 0, 0);
        drain();
        check("nop_pc_out", pc_out, 1);

        do_load(2);
        s0 = strobes;
        send(3, 0, 15, 2, 64'hAA, 0, 0);
        drain();
        check("irmovq_pc_out", pc_out, 12);
        check("irmovq_strobes", strobes - s0, 10);

        do_load(24);
        rdy_chk = 1;
        send(6, 0, 2, 4, 64'h0, 0, 0);
        send(7, 2, 0, 0, 64'h27, 0, 0);
        drain();
        rdy_chk = 0;
        check("b2b_span", wcyc[34] - wcyc[24], 10);
        check("b2b_pc_out", pc_out, 35);

        s0 = strobes;
        send(12, 0, 0, 0, 64'h0, 0, 0);
        drain();
        check("illegal_pc_out", pc_out, 35);
        check("illegal_strobes", strobes - s0, 0);

        do_load(1020);
        s0 = strobes;
        send(5, 0, 1, 2, 64'h1234, 0, 0);
        drain();
        check("ovf_strobes", strobes - s0, 0);
        check("ovf_pc_out", pc_out, 1020);
        send(1, 0, 0, 0, 64'h0, 0, 0);
        drain();
        check("ovf_nop_pc_out", pc_out, 1021);

        do_load(1014);
        send(3, 1, 15, 7, 64'h0123456789ABCDEF, 0, 0);
        send(1, 0, 0, 0, 64'h0, 0, 0);
        drain();
        check("end_of_mem_pc_out", pc_out, 0);

        send(9, 0, 0, 0, 64'h0, 1, 500);
        drain();
        check("load_accept_pc_out", pc_out, 501);

        s0 = strobes;
        send(3, 0, 15, 1, 64'hDEADBEEF, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check("abort_remaining", sb.size(), 7);
        sb.delete();
        pc_m = 0;
        rst = 0;
        check("abort_wr_en", wr_en, 0);
        check("abort_pc_out", pc_out, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("abort_strobes", strobes - s0, 3);

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) do_load($urandom_range(0, MEM - 1));
            else if (r == 1) do_load($urandom_range(990, MEM - 1));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            send($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 {$urandom, $urandom}, 0, 0);
        end
        drain();
        check("random_pc_out", pc_out, pc_m % MEM);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
